// File: rtl/ram_pkg.sv
// Shared definitions for the RAM access controller: default geometry and FSM state encoding.
package ram_pkg;

   localparam int RAM_WIDTH  = 8;
   localparam int RAM_DEPTH  = 16;
   localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

endpackage

// File: rtl/ram_req_if.sv
// Request/response handshake bus between a client (master) and the RAM access controller (slave).
interface ram_req_if #(
   parameter int WIDTH  = ram_pkg::RAM_WIDTH,
   parameter int ADDR_W = ram_pkg::RAM_ADDR_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [WIDTH-1:0]  req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/ram_init_seq.sv
// Address counter for the post-reset zero-fill sweep; steps once per enabled cycle.
module ram_init_seq
   import ram_pkg::*;
#(
   parameter int DEPTH  = RAM_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [ADDR_W-1:0] cnt_q;

   assign addr = cnt_q;
   assign last = (cnt_q == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-port RAM access controller with valid/ready request and read-response channels.
// Optional zero-fill sweep after reset is enabled by defining RAM_INIT_EN.
module ram_access_ctrl
   import ram_pkg::*;
#(
   parameter int WIDTH  = RAM_WIDTH,
   parameter int DEPTH  = RAM_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   ram_req_if.slave          req,
   output logic              ram_enable,
   output logic              ram_read_en,
   output logic [ADDR_W-1:0] ram_address,
   output logic [WIDTH-1:0]  ram_data_in,
   input  logic [WIDTH-1:0]  ram_data_out,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              rsp_valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  wdata_q;
   logic              req_ready;
   logic              accept;
   logic              sweep;
   logic              sweep_last;
   logic [ADDR_W-1:0] sweep_addr;

`ifdef RAM_INIT_EN
   localparam state_t RESET_STATE = ST_INIT;

   assign sweep = (state_q == ST_INIT) && !rst;

   ram_init_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_init_seq (
      .clk    (clk),
      .rst    (rst),
      .enable (sweep),
      .addr   (sweep_addr),
      .last   (sweep_last)
   );
`else
   localparam state_t RESET_STATE = ST_IDLE;

   assign sweep      = 1'b0;
   assign sweep_last = 1'b0;
   assign sweep_addr = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal driven here gets a default before the case so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      accept      = 1'b0;
      ram_enable  = 1'b0;
      ram_read_en = 1'b1;
      ram_address = addr_q;
      ram_data_in = wdata_q;
      unique case (state_q)
         ST_INIT: begin
            if (!rst) begin
               ram_enable  = 1'b1;
               ram_read_en = 1'b0;
               ram_address = sweep_addr;
               ram_data_in = '0;
               if (sweep_last) state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // A held response blocks new reads so rsp_rdata stays stable.
            req_ready = !rst && (!rsp_valid_q || req.rsp_ready);
            accept    = req.req_valid && req_ready;
            if (accept) begin
               ram_enable  = 1'b1;
               ram_read_en = !req.req_write;
               ram_address = req.req_addr;
               ram_data_in = req.req_wdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         if (accept && !req.req_write) begin
            rsp_valid_q <= 1'b1;
         end else if (req.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         // Idle RAM ports replay the last driven values instead of following the request bus.
         if (ram_enable) begin
            addr_q  <= ram_address;
            wdata_q <= ram_data_in;
         end
      end
   end

   assign req.req_ready = req_ready;
   assign req.rsp_valid = rsp_valid_q;
   assign req.rsp_rdata = ram_data_out;
   assign busy          = sweep;

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH, 8, data bits per word; DEPTH, 16, number of RAM words; ADDR_W, $clog2(DEPTH), address bits.
REQ-002 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, a request is presented.
REQ-005 SHALL have port req_ready, output, 1, the controller accepts the request this cycle.
REQ-006 SHALL have port req_write, input, 1, 1 = write request, 0 = read request.
REQ-007 SHALL have port req_addr, input, ADDR_W, request address.
REQ-008 SHALL have port req_wdata, input, WIDTH, write data.
REQ-009 SHALL have port rsp_valid, output, 1, read data is available.
REQ-010 SHALL have port rsp_ready, input, 1, the consumer takes the read data.
REQ-011 SHALL have port rsp_rdata, output, WIDTH, read data.
REQ-012 SHALL have port ram_enable, output, 1, drives the RAM enable.
REQ-013 SHALL have port ram_read_en, output, 1, drives the RAM read enable; a low value means write.
REQ-014 SHALL have port ram_address, output, ADDR_W, drives the RAM address.
REQ-015 SHALL have port ram_data_in, output, WIDTH, drives the RAM write data.
REQ-016 SHALL have port ram_data_out, input, WIDTH, RAM registered read data with 1-cycle latency.
REQ-017 SHALL have port busy, output, 1, the initialisation sweep is in progress.

Function
REQ-018 SHALL define acceptance as req_valid && req_ready at a rising edge; ram_enable SHALL equal acceptance (combinational), so the RAM samples at that same edge.
REQ-019 SHALL drive, on acceptance: ram_read_en = ~req_write, ram_address = req_addr, ram_data_in = req_wdata.
REQ-020 SHALL, when not accepting, drive ram_enable = 0, ram_read_en = 1 and the RAM data/address ports from registered last values (no glitch-driven writes).
REQ-021 SHALL set req_ready = (state == IDLE) && (!rsp_valid || rsp_ready).
REQ-022 SHALL assert rsp_valid on the cycle after an accepted read, and keep it asserted until a cycle with rsp_ready = 1.
REQ-023 SHALL drive rsp_rdata directly from ram_data_out; the value holds while rsp_valid = 1 because no new read is issued during that time.
REQ-024 SHALL complete an accepted write with no response.
REQ-025 SHALL sustain throughput of 1 request/cycle: back-to-back reads when rsp_ready stays high, and back-to-back writes always in IDLE.
REQ-026 SHALL use states INIT, IDLE, with transitions: rst -> INIT if RAM_INIT_EN, else IDLE; INIT -> IDLE after the last word is written; IDLE -> IDLE.
REQ-027 SHALL leave rsp_valid unchanged on a cycle where rsp_valid && !rsp_ready && req_valid; req_ready is 0 on that cycle.
REQ-028 SHALL raise rsp_valid for the new read in the next cycle when the response handshake and a new read acceptance occur in the same cycle.

Reset
REQ-029 SHALL give outputs these values on the cycle after rst = 1: rsp_valid 0, ram_enable 0, ram_read_en 1, ram_address 0, ram_data_in 0, req_ready 0 during rst.
REQ-030 SHALL discard a pending response when rst is asserted mid-operation; the RAM contents are not reset.
REQ-031 SHALL restart an INIT sweep from address 0 when rst is asserted during that sweep.

Configuration
REQ-032 SHALL, when macro RAM_INIT_EN is defined, enter INIT after rst and write 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), with busy = 1 and req_ready = 0; it then enters IDLE with busy = 0.
REQ-033 SHALL, when RAM_INIT_EN is undefined, go from rst straight to IDLE, with busy tied 0 and the sweep logic absent.

Structure
REQ-034 SHALL take WIDTH, DEPTH, ADDR_W defaults and the state encoding (INIT, IDLE) from shared package ram_pkg.
REQ-035 SHALL place the INIT address counter and sweep in sub-module ram_init_seq, instantiated only under RAM_INIT_EN.

Verification
REQ-036 SHALL cover: write 0xA5 @ 0x3, then read 0x3 with rsp_ready = 1 -> rsp_valid 1 cycle after acceptance, rsp_rdata 0xA5.
REQ-037 SHALL cover: read with rsp_ready = 0 for 5 cycles -> rsp_valid held, rsp_rdata stable, req_ready 0, ram_enable 0 throughout.
REQ-038 SHALL cover: 16 back-to-back writes then 16 back-to-back reads with rsp_ready = 1 -> one response per cycle, data matches, address wraps 0xF -> 0x0.
REQ-039 SHALL cover, with RAM_INIT_EN: release rst -> busy = 1 for 16 cycles with ram_enable = 1, ram_read_en = 0, ram_data_in 0; a read of 0x7 afterwards returns 0x00.
REQ-040 SHALL cover: rst pulse while rsp_valid = 1 -> rsp_valid = 0 the next cycle; a rst pulse mid-INIT at address 9 restarts the sweep at 0.
